enc_bundler: RTL

//  Downstream of the encoder binder packs: accepts NUM_IN bound (shifted) HVs per beat, NUM_BEATS beats per sample.

---
 rtl/enc_bundler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/enc_bundler.sv
`default_nettype none
// ============================================================================
//  Module   : enc_bundler
//  Purpose  : Accumulates per-bit set-bit counts of NUM_IN bound HVs per beat
//             over NUM_BEATS beats, thresholds the counts into one sparse
//             encoded HV and offers it downstream over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module enc_bundler #(
    parameter int HV_DIM    = 1024,
    parameter int NUM_IN    = 10,
    parameter int NUM_BEATS = 10,
    parameter int THRESHOLD = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_encoding,
    input  logic              in_valid,
    input  logic [HV_DIM-1:0] bound_hv [0:NUM_IN-1],
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HV_DIM-1:0] encoded_hv,
    output logic              busy
);

    // Counter holds the full NUM_IN*NUM_BEATS range, so it can never wrap.
    localparam int CNT_W  = $clog2(NUM_IN * NUM_BEATS + 1);
    localparam int BEAT_W = $clog2(NUM_BEATS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_THRESH = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CNT_W-1:0]  THRESH_CNT = CNT_W'(THRESHOLD);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NUM_BEATS - 1);

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic [HV_DIM-1:0] encoded_q;
    logic [CNT_W-1:0]  cnt_q [0:HV_DIM-1];
    logic [CNT_W-1:0]  w_inc [0:HV_DIM-1];
    logic              w_accept;
    logic              w_load_enc;

    // A start pulse aborts whatever is in flight, so it masks acceptance
    // and thresholding in the same cycle.
    assign w_accept   = in_valid && in_ready_q && (state_q == S_ACCUM) && !start_encoding;
    assign w_load_enc = (state_q == S_THRESH) && !start_encoding;

    // Per-bit column popcount across the NUM_IN bound HVs of this beat.
    always_comb begin
        for (int j = 0; j < HV_DIM; j++) begin
            w_inc[j] = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                w_inc[j] = w_inc[j] + CNT_W'(bound_hv[i][j]);
            end
        end
    end

    // Next-state and registered-output decode; start wins over everything
    // except reset, including the DONE handshake.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        if (start_encoding) begin
            state_d     = S_ACCUM;
            beat_cnt_d  = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_d    = S_THRESH;
                            in_ready_d = 1'b0;
                        end
                    end
                end
                S_THRESH: begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end
                S_DONE: begin
                    if (out_valid_q && out_ready) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    // Control state and handshake outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Per-bit accumulators: cleared on start, bumped on each accepted beat.
    always_ff @(posedge clk) begin
        for (int j = 0; j < HV_DIM; j++) begin
            if (!nrst || start_encoding) begin
                cnt_q[j] <= '0;
            end else if (w_accept) begin
                cnt_q[j] <= cnt_q[j] + w_inc[j];
            end
        end
    end

    // Encoded HV is captured once in THRESH and then held until the next one.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            encoded_q <= '0;
        end else if (w_load_enc) begin
            for (int j = 0; j < HV_DIM; j++) begin
                encoded_q[j] <= (cnt_q[j] >= THRESH_CNT);
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign encoded_hv = encoded_q;

endmodule
`default_nettype wire
